// File: rtl/ysyx_23060208_lsu.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_23060208_lsu
// Brief   : Single-outstanding load/store unit bridging EXU requests to AXI4.
// Revision: 1.0
// ============================================================================
module ysyx_23060208_lsu #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         XLEN       = 32,
  parameter int         BUS_WIDTH  = 64,
  parameter logic [3:0] AXI_ID     = 4'd1
) (
  input  logic                    clock,
  input  logic                    reset,
  // EXU request
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [XLEN-1:0]         req_wdata,
  // EXU response
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [XLEN-1:0]         resp_rdata,
  output logic                    resp_err,
  output logic                    resp_misalign,
  // AXI4 AW
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [3:0]              awid,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  // AXI4 W
  output logic                    wvalid,
  input  logic                    wready,
  output logic [BUS_WIDTH-1:0]    wdata,
  output logic [BUS_WIDTH/8-1:0]  wstrb,
  output logic                    wlast,
  // AXI4 B
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  input  logic [3:0]              bid,
  // AXI4 AR
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [3:0]              arid,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  // AXI4 R
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [BUS_WIDTH-1:0]    rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic [3:0]              rid
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;
  localparam int LANE_BITS  = $clog2(STRB_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_RESP = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  unsigned_q, unsigned_d;
  logic                  wen_q, wen_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [XLEN-1:0]       resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic                  resp_misalign_q, resp_misalign_d;

  logic                  req_misalign;
  logic [LANE_BITS-1:0]  lane;
  logic [LANE_BITS+2:0]  bit_off;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_word;
  logic [XLEN-1:0]       load_ext;
  logic [STRB_WIDTH-1:0] strb_base;
  logic                  aw_fire;
  logic                  w_fire;
  logic                  unused_rlast;

  // rlast is implied by arlen = 0; the single R beat is the last one.
  assign unused_rlast = rlast;

  always_comb begin
    req_misalign = 1'b0;
    case (req_size)
      2'd1:    req_misalign = req_addr[0];
      2'd2:    req_misalign = (req_addr[1:0] != 2'b00);
      2'd3:    req_misalign = 1'b1;
      default: req_misalign = 1'b0;
    endcase
  end

  assign lane    = addr_q[LANE_BITS-1:0];
  assign bit_off = {lane, 3'b000};
  assign ld_byte = rdata[bit_off +: 8];
  assign ld_half = rdata[bit_off +: 16];
  assign ld_word = rdata[bit_off +: 32];

  always_comb begin
    load_ext = '0;
    case (size_q)
      2'd0: begin
        if (unsigned_q) load_ext = XLEN'(ld_byte);
        else            load_ext = XLEN'($signed(ld_byte));
      end
      2'd1: begin
        if (unsigned_q) load_ext = XLEN'(ld_half);
        else            load_ext = XLEN'($signed(ld_half));
      end
      default: begin
        if (unsigned_q) load_ext = XLEN'(ld_word);
        else            load_ext = XLEN'($signed(ld_word));
      end
    endcase
  end

  always_comb begin
    strb_base = '0;
    case (size_q)
      2'd0:    strb_base = STRB_WIDTH'(1'b1);
      2'd1:    strb_base = STRB_WIDTH'(2'b11);
      default: strb_base = STRB_WIDTH'(4'hF);
    endcase
  end

  // Valids are derived from state, so a handshake in AW_W only needs the ready.
  assign aw_fire = aw_done_q | awready;
  assign w_fire  = w_done_q | wready;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    size_d          = size_q;
    unsigned_d      = unsigned_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    aw_done_d       = aw_done_q;
    w_done_d        = w_done_q;
    resp_rdata_d    = resp_rdata_q;
    resp_err_d      = resp_err_q;
    resp_misalign_d = resp_misalign_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          wen_d      = req_wen;
          wdata_d    = req_wdata;
          if (req_misalign) begin
            state_d         = S_RESP;
            resp_rdata_d    = '0;
            resp_err_d      = 1'b1;
            resp_misalign_d = 1'b1;
          end else begin
            state_d = req_wen ? S_AW_W : S_AR;
          end
        end
      end
      S_AR: begin
        if (arready) state_d = S_R;
      end
      S_R: begin
        if (rvalid) begin
          state_d         = S_RESP;
          resp_rdata_d    = wen_q ? '0 : load_ext;
          resp_err_d      = (rresp != 2'b00) || (rid != AXI_ID);
          resp_misalign_d = 1'b0;
        end
      end
      S_AW_W: begin
        if (aw_fire && w_fire) begin
          state_d   = S_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_fire;
          w_done_d  = w_fire;
        end
      end
      S_B: begin
        if (bvalid) begin
          state_d         = S_RESP;
          resp_rdata_d    = '0;
          resp_err_d      = (bresp != 2'b00) || (bid != AXI_ID);
          resp_misalign_d = 1'b0;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      size_q          <= '0;
      unsigned_q      <= 1'b0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      aw_done_q       <= 1'b0;
      w_done_q        <= 1'b0;
      resp_rdata_q    <= '0;
      resp_err_q      <= 1'b0;
      resp_misalign_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      size_q          <= size_d;
      unsigned_q      <= unsigned_d;
      wen_q           <= wen_d;
      wdata_q         <= wdata_d;
      aw_done_q       <= aw_done_d;
      w_done_q        <= w_done_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_err_q      <= resp_err_d;
      resp_misalign_q <= resp_misalign_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = (state_q == S_RESP);
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign resp_misalign = resp_misalign_q;

  assign arvalid = (state_q == S_AR);
  assign araddr  = addr_q;
  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign rready  = (state_q == S_R);

  assign awvalid = (state_q == S_AW_W) && !aw_done_q;
  assign awaddr  = addr_q;
  assign awid    = AXI_ID;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = 2'b01;

  assign wvalid  = (state_q == S_AW_W) && !w_done_q;
  assign wdata   = BUS_WIDTH'(wdata_q) << bit_off;
  assign wstrb   = strb_base << lane;
  assign wlast   = 1'b1;
  assign bready  = (state_q == S_B);

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060208_lsu.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_23060208_lsu
// Brief   : Directed self-checking bench for the LSU with a scripted AXI slave.
// Revision: 1.0
// ============================================================================
module tb_ysyx_23060208_lsu;

  logic        clock;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err, resp_misalign;
  logic [31:0] resp_rdata;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready, wlast;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;

  int checks = 0;
  int errors = 0;

  // Per-transaction observations gathered by the scripted slave.
  int          lat, n_ar, n_aw, n_w;
  logic [31:0] cap_araddr, cap_awaddr;
  logic [2:0]  cap_arsize, cap_awsize;
  logic [7:0]  cap_arlen;
  logic [1:0]  cap_arburst;
  logic [3:0]  cap_arid;
  logic [63:0] cap_wdata;
  logic [7:0]  cap_wstrb;
  logic        cap_wlast;
  int          seen_resp;

  ysyx_23060208_lsu dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_misalign(resp_misalign),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and play a well-behaved slave until resp_valid or budget.
  task automatic xact(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wd, input logic [63:0] rd,
                      input logic [1:0] xresp, input logic [3:0] xid,
                      input int aw_delay, input int w_delay);
    int cyc;
    n_ar = 0; n_aw = 0; n_w = 0;
    cap_araddr = '0; cap_awaddr = '0; cap_arsize = '0; cap_awsize = '0;
    cap_arlen = '1; cap_arburst = '0; cap_arid = '0;
    cap_wdata = '0; cap_wstrb = '0; cap_wlast = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    @(negedge clock);
    req_valid = 1'b0;
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 30) begin
      arready = 1'b1;
      rvalid  = rready; rdata = rd; rresp = xresp; rid = xid; rlast = 1'b1;
      awready = (cyc >= 1 + aw_delay);
      wready  = (cyc >= 1 + w_delay);
      bvalid  = bready; bresp = xresp; bid = xid;
      if (arvalid) begin
        cap_araddr = araddr; cap_arsize = arsize; cap_arlen = arlen;
        cap_arburst = arburst; cap_arid = arid;
        n_ar++;
      end
      if (awvalid && awready) begin
        cap_awaddr = awaddr; cap_awsize = awsize;
        n_aw++;
      end
      if (wvalid && wready) begin
        cap_wdata = wdata; cap_wstrb = wstrb; cap_wlast = wlast;
        n_w++;
      end
      @(negedge clock);
      cyc++;
    end
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    lat = cyc;
    chk("resp_arrived", resp_valid, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;

    repeat (2) @(negedge clock);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
    chk("rst_readies", {rready, bready}, 2'b00);
    chk("rst_resp_fields", {resp_rdata, resp_err, resp_misalign}, 34'd0);
    reset = 1'b1;

    // Load word, lane 4 of a 64-bit beat; response held while resp_ready low
    xact(1'b0, 32'h8000_0004, 2'd2, 1'b0, '0, 64'h1122_3344_AABB_CCDD, 2'b00, 4'd1, 0, 0);
    chk("lw_latency", lat, 3);
    chk("lw_ar_beats", n_ar, 1);
    chk("lw_araddr", cap_araddr, 32'h8000_0004);
    chk("lw_arsize", cap_arsize, 3'd2);
    chk("lw_arlen_burst_id", {cap_arlen, cap_arburst, cap_arid}, {8'd0, 2'b01, 4'd1});
    chk("lw_rdata", resp_rdata, 32'h1122_3344);
    chk("lw_err_mis", {resp_err, resp_misalign}, 2'b00);
    @(negedge clock);
    chk("lw_hold_valid", resp_valid, 1'b1);
    chk("lw_hold_rdata", resp_rdata, 32'h1122_3344);
    chk("lw_no_req_ready", req_ready, 1'b0);
    resp_ready = 1'b1;

    // Signed and unsigned byte load from lane 3
    xact(1'b0, 32'h8000_0003, 2'd0, 1'b0, '0, 64'h5566_7788_80AA_BBCC, 2'b00, 4'd1, 0, 0);
    chk("lb_signed", resp_rdata, 32'hFFFF_FF80);
    xact(1'b0, 32'h8000_0003, 2'd0, 1'b1, '0, 64'h5566_7788_80AA_BBCC, 2'b00, 4'd1, 0, 0);
    chk("lbu_unsigned", resp_rdata, 32'h0000_0080);

    // Half loads: signed from top lanes, unsigned from lane 2
    xact(1'b0, 32'h8000_0006, 2'd1, 1'b0, '0, 64'h8001_2222_9ABC_4444, 2'b00, 4'd1, 0, 0);
    chk("lh_signed", resp_rdata, 32'hFFFF_8001);
    xact(1'b0, 32'h8000_0002, 2'd1, 1'b1, '0, 64'h8001_2222_9ABC_4444, 2'b00, 4'd1, 0, 0);
    chk("lhu_unsigned", resp_rdata, 32'h0000_9ABC);

    // Store half, awready two cycles after the W handshake
    xact(1'b1, 32'h8000_0006, 2'd1, 1'b0, 32'h0000_BEEF, '0, 2'b00, 4'd1, 2, 0);
    chk("sh_wstrb", cap_wstrb, 8'hC0);
    chk("sh_wdata_hi", cap_wdata[63:48], 16'hBEEF);
    chk("sh_beats", {n_aw[7:0], n_w[7:0]}, 16'h0101);
    chk("sh_awaddr_size", {cap_awaddr, cap_awsize}, {32'h8000_0006, 3'd1});
    chk("sh_wlast", cap_wlast, 1'b1);
    chk("sh_latency", lat, 5);
    chk("sh_resp", {resp_rdata, resp_err, resp_misalign}, 34'd0);

    // Store word, W accepted one cycle after AW
    xact(1'b1, 32'h8000_0000, 2'd2, 1'b0, 32'hDEAD_BEEF, '0, 2'b00, 4'd1, 0, 1);
    chk("sw_wstrb", cap_wstrb, 8'h0F);
    chk("sw_wdata_lo", cap_wdata[31:0], 32'hDEAD_BEEF);
    chk("sw_beats", {n_aw[7:0], n_w[7:0]}, 16'h0101);
    chk("sw_latency", lat, 4);

    // Store byte, zero-wait slave but SLVERR response
    xact(1'b1, 32'h8000_0005, 2'd0, 1'b0, 32'h0000_00A5, '0, 2'b10, 4'd1, 0, 0);
    chk("sb_wstrb", cap_wstrb, 8'h20);
    chk("sb_wdata_b5", cap_wdata[47:40], 8'hA5);
    chk("sb_latency", lat, 3);
    chk("sb_slverr", {resp_err, resp_misalign}, 2'b10);

    // Misaligned word load: no AXI traffic, immediate response
    xact(1'b0, 32'h8000_0002, 2'd2, 1'b0, '0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 4'd1, 0, 0);
    chk("mis_latency", lat, 1);
    chk("mis_no_ar", n_ar, 0);
    chk("mis_flags", {resp_err, resp_misalign}, 2'b11);
    chk("mis_rdata", resp_rdata, 32'd0);

    // Size 3 store is always misaligned
    xact(1'b1, 32'h8000_0000, 2'd3, 1'b0, 32'h1234_5678, '0, 2'b00, 4'd1, 0, 0);
    chk("mis3_no_aw_w", {n_aw[7:0], n_w[7:0]}, 16'h0000);
    chk("mis3_flags", {resp_err, resp_misalign}, 2'b11);

    // Load with wrong RID: error flagged, data still extracted
    xact(1'b0, 32'h8000_0000, 2'd2, 1'b0, '0, 64'h0000_0000_CAFE_F00D, 2'b00, 4'd2, 0, 0);
    chk("rid_err", {resp_err, resp_misalign}, 2'b10);
    chk("rid_rdata", resp_rdata, 32'hCAFE_F00D);

    // Reset asserted while waiting in R
    @(negedge clock);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0000; req_size = 2'd2;
    req_unsigned = 1'b0;
    @(negedge clock);
    req_valid = 1'b0; arready = 1'b1;
    @(negedge clock);
    arready = 1'b0;
    chk("rst_mid_in_r", rready, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_rready", rready, 1'b0);
    chk("rst_mid_req_ready", req_ready, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    seen_resp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (resp_valid === 1'b1) seen_resp++;
    end
    chk("rst_mid_no_resp", seen_resp, 0);
    chk("rst_mid_idle", req_ready, 1'b1);

    // Recovery: unsigned byte load from the top lane
    xact(1'b0, 32'h8000_0007, 2'd0, 1'b1, '0, 64'hF100_0000_0000_0000, 2'b00, 4'd1, 0, 0);
    chk("rec_rdata", resp_rdata, 32'h0000_00F1);
    chk("rec_latency", lat, 3);

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_23060208_lsu.md
YSYX_23060208_LSU -- requirements
Module: ysyx_23060208_lsu

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, address width; XLEN, default 32, register data width; BUS_WIDTH, default 64, AXI data width (32 or 64, at least XLEN); AXI_ID, default 1, 4-bit ID driven on arid/awid.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports as follows (name, direction, width, meaning):
- clock, in, 1, the single clock.
- reset, in, 1, asynchronous active-low reset.
REQ-003 SHALL have the request ports from EXU:
- req_valid, in, 1.
- req_ready, out, 1.
- req_wen, in, 1, 1 = store.
- req_addr, in, ADDR_WIDTH.
- req_size, in, 2, 0 = byte, 1 = half, 2 = word.
- req_unsigned, in, 1, zero-extend loads.
- req_wdata, in, XLEN.
REQ-004 SHALL have the response ports:
- resp_valid, out, 1.
- resp_ready, in, 1.
- resp_rdata, out, XLEN.
- resp_err, out, 1.
- resp_misalign, out, 1.
REQ-005 SHALL have the AXI4 master ports:
- AW channel: awvalid/awready, awaddr ADDR_WIDTH, awid 4, awlen 8, awsize 3, awburst 2.
- W channel: wvalid/wready, wdata BUS_WIDTH, wstrb BUS_WIDTH/8, wlast.
- B channel: bvalid/bready, bresp 2, bid 4.
- AR channel: arvalid/arready, araddr ADDR_WIDTH, arid 4, arlen 8, arsize 3, arburst 2.
- R channel: rvalid/rready, rdata BUS_WIDTH, rresp 2, rlast, rid 4.

Function
REQ-006 SHALL hold at most one outstanding transaction; req_ready = 1 only in IDLE.
REQ-007 SHALL use states IDLE, AR, R, AW_W, B, RESP; the request handshake moves IDLE to AR (load) or AW_W (store) in the same cycle the request is latched.
REQ-008 SHALL register addr, size, unsigned, wen and wdata at the request handshake; bus outputs derive only from registered values.
REQ-009 SHALL flag a misaligned access (half with addr[0] = 1; word with addr[1:0] != 0; size = 3) as follows: go IDLE -> RESP directly with resp_misalign = 1, resp_err = 1, resp_rdata = 0, and issue no AXI traffic.
REQ-010 SHALL drive AR fields as follows: araddr = registered addr (unaligned low bits kept), arsize = req_size, arlen = 0, arburst = 2'b01 (INCR), arid = AXI_ID; AW uses the same rules.
REQ-011 SHALL hold arvalid high throughout AR and keep its payload stable until arready; on handshake go AR -> R.
REQ-012 SHALL keep rready = 1 throughout R; the rvalid&&rready beat (rlast expected 1) moves R -> RESP and captures data and rresp.
REQ-013 SHALL extract load data from byte lane L = addr mod (BUS_WIDTH/8), then sign- or zero-extend it to XLEN per req_size and req_unsigned.
REQ-014 SHALL raise awvalid and wvalid together in AW_W and track each handshake independently with a done flag.
- The AW_W -> B transition occurs when both handshakes are done, including when both complete in the same cycle or in either order.
- A completed channel deasserts its valid the cycle after its handshake.
REQ-015 SHALL, for stores:
- replicate the data into byte lane L as wdata = req_wdata shifted left by 8*L, with bytes above the access size don't-care;
- drive wstrb = ((1 << 2^size) - 1) << L;
- drive wlast = 1.
REQ-016 SHALL keep bready = 1 throughout B; the bvalid beat moves B -> RESP and captures bresp.
REQ-017 SHALL set resp_err = 1 when the captured rresp/bresp is not 2'b00, or when rid/bid does not equal AXI_ID; even on error, load data is still extracted.
REQ-018 SHALL hold resp_valid = 1 throughout RESP with all response fields stable; resp_valid&&resp_ready moves RESP -> IDLE, and a new request is accepted no earlier than the next cycle.
REQ-019 SHALL drive resp_rdata = 0 for stores.
REQ-020 SHALL have the following latency with zero-wait slaves and resp_ready = 1: load = 3 cycles and store = 3 cycles from request handshake to resp_valid.
REQ-021 SHALL hold all address/data payloads stable while the corresponding valid is high and not yet accepted (AXI rule); a valid, once asserted, never drops before its ready.

Reset
REQ-022 SHALL, while reset = 0 (asynchronous assertion), force IDLE and drive all valid/ready outputs except req_ready to 0, req_ready to 1, and resp fields, done flags and captured registers to 0.
REQ-023 SHALL, on reset assertion mid-transaction, abandon the transaction immediately with no response; release of reset is synchronous to the clock edge.

Verification
REQ-024 SHALL pass this case: load word at 0x80000004, BUS_WIDTH = 64, rdata = 0x11223344_AABBCCDD -> arsize = 2, resp_rdata = 0x11223344, resp_err = 0.
REQ-025 SHALL pass this case: signed load byte at 0x80000003 with byte lane 3 = 0x80 -> resp_rdata = 0xFFFFFF80; the same access with req_unsigned = 1 -> 0x00000080.
REQ-026 SHALL pass this case: store half 0xBEEF at 0x80000006 (64-bit bus) -> wstrb = 0xC0, wdata[63:48] = 0xBEEF; with awready 2 cycles after wready, exactly one AW and one W beat are issued and resp_valid follows bvalid.
REQ-027 SHALL pass this case: load word at 0x80000002 -> no arvalid ever, resp_valid next cycle, resp_misalign = 1, resp_err = 1.
REQ-028 SHALL pass this case: bresp = 2'b10 (SLVERR) on a store -> resp_err = 1, resp_misalign = 0.
REQ-029 SHALL pass this case: reset = 0 asserted while in R with rvalid low -> rready = 0, req_ready = 1 immediately, and no resp_valid after release.
